mac_dot_sequencer: RTL
======================

Name: mac_dot_sequencer

Overview:
Initiator side of the MAC unit's valid/done operand protocol. It buffers signed 8-bit operand pairs from an upstream stream and issues them one at a time to a mac_unit instance. It clears the MAC accumulator at the start of every vector and returns the 32-bit dot-product result plus element count on a valid/ready result port. One sequencer drives exactly one mac_unit.

Parameters:
DEPTH, 4, operand FIFO entries (power of two, >=2)
CNT_W, 16, width of element counter / res_count
TIMEOUT, 15, max cycles waiting for mac_done (used only with MAC_SEQ_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream operand pair valid
in_ready  output  1  FIFO can accept (= !full)
in_a  input  8  signed operand A
in_b  input  8  signed operand B
in_last  input  1  pair is final element of current vector
mac_clr  output  1  drives mac_unit reset; one-cycle pulse
mac_valid  output  1  drives mac_unit valid; one-cycle pulse
mac_a  output  8  drives mac_unit A
mac_b  output  8  drives mac_unit B
mac_done  input  1  mac_unit done
mac_y  input  32  mac_unit accumulator output
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  32  signed dot product
res_count  output  CNT_W  elements accumulated (saturating)
err_timeout  output  1  sticky watchdog error (feature-dependent)

Behaviour:
- Reset values: in_ready=0 during reset, 1 afterwards while FIFO empty; mac_clr=0, mac_valid=0, mac_a=0, mac_b=0, res_valid=0, res_data=0, res_count=0, err_timeout=0. FIFO emptied, counter=0, new_vec flag=1, state=IDLE.
- FIFO: stores {a,b,last}; push when in_valid&&in_ready; pop only on mac_done in WAIT. in_ready=!full; no bypass, so a push to a full FIFO is refused even if a pop happens in the same cycle. Pointers wrap modulo DEPTH; separate count for full/empty.
- FSM (registered outputs):
  - IDLE: if FIFO non-empty and res_valid=0: go to CLEAR when new_vec=1, else ISSUE. Otherwise stay.
  - CLEAR: mac_clr=1 for exactly 1 cycle; counter<=0; new_vec<=0; -> RECOVER.
  - RECOVER: 1 idle cycle so the MAC's internal clear deasserts; -> ISSUE.
  - ISSUE: mac_valid=1 for 1 cycle; mac_a/mac_b = FIFO head; -> WAIT.
  - WAIT: mac_a/mac_b held stable. On mac_done: pop; counter+1, saturating at 2^CNT_W-1. If head.last: -> SETTLE, else -> IDLE.
  - SETTLE: 1 cycle, because mac_y updates the cycle after mac_done. -> RESULT.
  - RESULT: capture res_data<=mac_y, res_count<=counter; res_valid<=1; new_vec<=1; -> IDLE.
- Result handshake: res_valid stays high with res_data/res_count stable until res_valid&&res_ready. No new element is issued while res_valid=1, which gives backpressure into the FIFO.
- Latency: from a pair at FIFO head in IDLE to mac_valid is 1 cycle (continuing vector) or 3 cycles (new vector). From the last mac_done to res_valid is 2 cycles.
- mac_done outside WAIT is ignored.
- Reset mid-operation: everything returns to reset values; the partial vector is discarded; the next vector starts with CLEAR.
- Zero-length vectors do not exist; every result has count >=1.

Optional Feature:
MAC_SEQ_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT. If mac_done has not arrived after TIMEOUT cycles:
  - set err_timeout (sticky until reset);
  - flush the FIFO entries up to and including the next last=1 entry;
  - return to IDLE with new_vec=1;
  - produce no result for that vector.
- Undefined: err_timeout tied to 0 and WAIT waits indefinitely.

Test Plan:
- Single vector (3,4),(−2,5),(7,−1,last) with a model MAC -> exactly one mac_clr pulse; three mac_valid pulses with matching mac_a/mac_b; res_data=−5, res_count=3.
- Two back-to-back vectors [(10,10,last)] then [(1,1),(2,2,last)] -> mac_clr precedes each vector; results 100/count 1, then 5/count 2.
- Fill FIFO with DEPTH+1 pairs while res_ready=0 and a prior result is pending -> in_ready=0 after DEPTH pushes; no pair lost or duplicated after res_ready=1.
- Extremes (−128,−128)x2 last -> res_data=32768, count=2; mac_a/mac_b stable throughout WAIT.
- Assert reset during WAIT of element 2 of 3 -> all outputs reset; the next vector (6,7,last) yields 42/count 1.
- With MAC_SEQ_TIMEOUT_EN, TIMEOUT=15, model MAC never asserts done -> err_timeout=1 on the 15th WAIT cycle; vector flushed; res_valid stays 0.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: buffers signed operand pairs and sequences them through one mac_unit, returning dot products.
// Define MAC_SEQ_TIMEOUT_EN to add the mac_done watchdog (sticky err_timeout, flush of the stalled vector).
module mac_dot_sequencer #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             mac_clr,
    output logic             mac_valid,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic             mac_done,
    input  logic [31:0]      mac_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("mac_dot_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, RECOVER, ISSUE, WAIT, SETTLE, RESULT, FLUSH} state_t;

    state_t           state_q;
    logic [16:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] elem_q;
    logic             new_vec_q, in_ready_q, mac_clr_q, mac_valid_q, res_valid_q;
    logic [7:0]       mac_a_q, mac_b_q;
    logic [31:0]      res_data_q;
    logic [CNT_W-1:0] res_count_q;
    logic [16:0]      head;
    logic             push, pop, timeout, flush_pop;

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_q;
    logic          err_q;
    assign timeout     = state_q == WAIT && !mac_done && tmr_q == TW'(TIMEOUT - 1);
    assign flush_pop   = state_q == FLUSH && cnt_q != '0;
    assign err_timeout = err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= state_q == WAIT ? tmr_q + 1'b1 : '0;
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout     = 1'b0;
    assign flush_pop   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // No bypass: a full FIFO refuses a push even when a pop happens in the same cycle.
    assign head  = mem_q[rd_ptr_q];
    assign push  = in_valid && in_ready_q;
    assign pop   = (state_q == WAIT && mac_done) || flush_pop;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    assign in_ready  = in_ready_q;
    assign mac_clr   = mac_clr_q;
    assign mac_valid = mac_valid_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_count = res_count_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_last};
    end

    // Outputs are registered: each pulse is launched on the transition into the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            elem_q      <= '0;
            new_vec_q   <= 1'b1;
            mac_clr_q   <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + AW'(push);
            rd_ptr_q    <= rd_ptr_q + AW'(pop);
            cnt_q       <= cnt_d;
            in_ready_q  <= cnt_d != CW'(DEPTH);
            mac_clr_q   <= 1'b0;
            mac_valid_q <= 1'b0;
            if (res_valid_q && res_ready) res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cnt_q != '0 && !res_valid_q) begin
                        state_q   <= new_vec_q ? CLEAR : ISSUE;
                        mac_clr_q <= new_vec_q;
                        if (!new_vec_q) begin
                            mac_valid_q <= 1'b1;
                            mac_a_q     <= head[16:9];
                            mac_b_q     <= head[8:1];
                        end
                    end
                end
                CLEAR: begin
                    state_q   <= RECOVER;
                    elem_q    <= '0;
                    new_vec_q <= 1'b0;
                end
                RECOVER: begin
                    state_q     <= ISSUE;
                    mac_valid_q <= 1'b1;
                    mac_a_q     <= head[16:9];
                    mac_b_q     <= head[8:1];
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (mac_done) begin
                        elem_q  <= elem_q == '1 ? elem_q : elem_q + 1'b1;
                        state_q <= head[0] ? SETTLE : IDLE;
                    end else if (timeout) begin
                        state_q <= FLUSH;
                    end
                end
                SETTLE: begin
                    state_q     <= RESULT;
                    res_valid_q <= 1'b1;
                    res_data_q  <= mac_y;
                    res_count_q <= elem_q;
                end
                RESULT: begin
                    state_q   <= IDLE;
                    new_vec_q <= 1'b1;
                end
                FLUSH: begin
                    if (flush_pop && head[0]) begin
                        state_q   <= IDLE;
                        new_vec_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
